cache_control: RTL and testbench

Control unit for the 2-way set-associative, write-back, write-allocate cache built from two `way` instances. It sits between the CPU memory port and physical memory. It resolves hits from the two ways' valid/tag outputs and keeps one LRU bit per set. It sequences write-back and allocate transactions on the physical-memory port and drives every load/valid/dirty control of both ways. It also runs a post-reset invalidate sweep, because the way arrays themselves have no reset.

---
 rtl/lc3b_types.sv | 20 ++
 rtl/cache_control.sv | 176 +++++++++++++++++
 tb/tb_cache_control.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b cache types: address fields, line width and
// the cache controller state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [8:0]   lc3b_c_tag;
  typedef logic [2:0]   lc3b_c_index;
  typedef logic [3:0]   lc3b_c_offset;
  typedef logic [127:0] lc3b_c_line;

  localparam int unsigned N_SETS = 8;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_WRITEBACK,
    S_ALLOCATE
  } cache_state_t;

endpackage

// File: rtl/cache_control.sv
// Control for the 2-way write-back, write-allocate cache: hit
// detection, per-set LRU, pmem write-back/allocate sequencing,
// post-reset invalidate sweep.
// Ports: clk/reset; CPU mem_read/mem_write/mem_address/mem_resp;
// pmem_read/pmem_write/pmem_address/pmem_resp; way status
// v*/d*/tag*_out; way controls index, tag_in, load_*, d_in,
// v_in, data_sel, way_sel.
module cache_control
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  lc3b_word    mem_address,
  output logic        mem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output lc3b_word    pmem_address,
  input  logic        pmem_resp,
  output lc3b_c_index index,
  output lc3b_c_tag   tag_in,
  input  logic        v0_out,
  input  logic        d0_out,
  input  logic        v1_out,
  input  logic        d1_out,
  input  lc3b_c_tag   tag0_out,
  input  lc3b_c_tag   tag1_out,
  output logic        load_d0,
  output logic        load_v0,
  output logic        load_TD0,
  output logic        load_d1,
  output logic        load_v1,
  output logic        load_TD1,
  output logic        d_in,
  output logic        v_in,
  output logic        data_sel,
  output logic        way_sel
);

  cache_state_t state, state_next;
  lc3b_c_index  init_cnt;
  logic [N_SETS-1:0] lru;
  logic         victim_q;

  lc3b_c_tag    addr_tag;
  lc3b_c_index  addr_idx;
  logic         hit0, hit1, hit, hit_way;
  logic         victim, victim_dirty;
  logic         req;
  logic         lru_we, lru_val;
  lc3b_c_tag    victim_tag;

  assign addr_tag = mem_address[15:7];
  assign addr_idx = mem_address[6:4];
  assign tag_in   = addr_tag;
  assign index    = (state == S_INIT) ? init_cnt : addr_idx;

  // Way 0 wins if both ways ever claim the line.
  assign hit0    = v0_out & (tag0_out == addr_tag);
  assign hit1    = v1_out & (tag1_out == addr_tag) & ~hit0;
  assign hit     = hit0 | hit1;
  assign hit_way = hit1;

  assign victim       = lru[index];
  assign victim_dirty = victim ? (v1_out & d1_out)
                               : (v0_out & d0_out);
  assign victim_tag   = victim_q ? tag1_out : tag0_out;
  assign req          = mem_read | mem_write;

  always_comb begin
    state_next   = state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 16'h0000;
    load_d0      = 1'b0;
    load_v0      = 1'b0;
    load_TD0     = 1'b0;
    load_d1      = 1'b0;
    load_v1      = 1'b0;
    load_TD1     = 1'b0;
    d_in         = 1'b0;
    v_in         = 1'b0;
    data_sel     = 1'b0;
    way_sel      = 1'b0;
    lru_we       = 1'b0;
    lru_val      = 1'b0;

    unique case (state)
      S_INIT: begin
        load_v0 = 1'b1;
        load_v1 = 1'b1;
        load_d0 = 1'b1;
        load_d1 = 1'b1;
        if (init_cnt == 3'd7)
          state_next = S_IDLE;
      end

      S_IDLE: begin
        way_sel = hit ? hit_way : victim;
        if (req) begin
          if (hit) begin
            mem_resp = 1'b1;
            lru_we   = 1'b1;
            lru_val  = ~hit_way;
            // Write wins when both strobes are high.
            if (mem_write) begin
              d_in     = 1'b1;
              v_in     = 1'b1;
              data_sel = 1'b0;
              load_TD0 = ~hit_way;
              load_d0  = ~hit_way;
              load_v0  = ~hit_way;
              load_TD1 = hit_way;
              load_d1  = hit_way;
              load_v1  = hit_way;
            end
          end else if (victim_dirty) begin
            state_next = S_WRITEBACK;
          end else begin
            state_next = S_ALLOCATE;
          end
        end
      end

      S_WRITEBACK: begin
        way_sel      = victim_q;
        pmem_write   = 1'b1;
        pmem_address = {victim_tag, addr_idx, 4'h0};
        if (pmem_resp)
          state_next = S_ALLOCATE;
      end

      S_ALLOCATE: begin
        way_sel      = victim_q;
        pmem_read    = 1'b1;
        pmem_address = {addr_tag, addr_idx, 4'h0};
        if (pmem_resp) begin
          v_in       = 1'b1;
          d_in       = 1'b0;
          data_sel   = 1'b1;
          load_TD0   = ~victim_q;
          load_v0    = ~victim_q;
          load_d0    = ~victim_q;
          load_TD1   = victim_q;
          load_v1    = victim_q;
          load_d1    = victim_q;
          state_next = S_IDLE;
        end
      end

      default: state_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_INIT;
      init_cnt <= '0;
      lru      <= '0;
      victim_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_INIT)
        init_cnt <= init_cnt + 3'd1;
      // Tracks the victim every idle cycle; the value held on
      // leaving idle steers the whole miss sequence.
      if (state == S_IDLE)
        victim_q <= victim;
      if (lru_we)
        lru[index] <= lru_val;
    end
  end

endmodule

// File: tb/tb_cache_control.sv
// Scoreboard bench for cache_control with behavioural way
// arrays and a pmem responder with programmable latency.
module tb_cache_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [15:0] mem_address;
  logic        mem_resp;
  logic        pmem_read, pmem_write;
  logic [15:0] pmem_address;
  logic        pmem_resp;
  logic [2:0]  index;
  logic [8:0]  tag_in;
  logic        v0_out, d0_out, v1_out, d1_out;
  logic [8:0]  tag0_out, tag1_out;
  logic        load_d0, load_v0, load_TD0;
  logic        load_d1, load_v1, load_TD1;
  logic        d_in, v_in, data_sel, way_sel;

  cache_control dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_resp(pmem_resp),
    .index(index), .tag_in(tag_in),
    .v0_out(v0_out), .d0_out(d0_out),
    .v1_out(v1_out), .d1_out(d1_out),
    .tag0_out(tag0_out), .tag1_out(tag1_out),
    .load_d0(load_d0), .load_v0(load_v0),
    .load_TD0(load_TD0), .load_d1(load_d1),
    .load_v1(load_v1), .load_TD1(load_TD1),
    .d_in(d_in), .v_in(v_in),
    .data_sel(data_sel), .way_sel(way_sel)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Way arrays: no reset, power up valid+dirty with way 0
  // holding the tag of 0x1234 so a missed sweep shows up.
  logic       wv [2][8];
  logic       wd [2][8];
  logic [8:0] wt [2][8];

  initial begin
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 8; s++) begin
        wv[w][s] = 1'b1;
        wd[w][s] = 1'b1;
        wt[w][s] = (w == 0) ? 9'h024 : 9'($urandom);
      end
  end

  always @(posedge clk) begin
    if (load_v0)  wv[0][index] <= v_in;
    if (load_d0)  wd[0][index] <= d_in;
    if (load_TD0) wt[0][index] <= tag_in;
    if (load_v1)  wv[1][index] <= v_in;
    if (load_d1)  wd[1][index] <= d_in;
    if (load_TD1) wt[1][index] <= tag_in;
  end

  assign v0_out   = wv[0][index];
  assign d0_out   = wd[0][index];
  assign tag0_out = wt[0][index];
  assign v1_out   = wv[1][index];
  assign d1_out   = wd[1][index];
  assign tag1_out = wt[1][index];

  // pmem responder: raises pmem_resp in the delay-th cycle of
  // each transaction and checks the request holds steady.
  int          delay = 1;
  int          cnt = 0;
  logic [15:0] st_addr;
  logic [1:0]  st_rw;

  initial pmem_resp = 1'b0;

  always @(posedge clk) begin
    #2;
    if (reset) begin
      cnt = 0;
      pmem_resp = 1'b0;
    end else begin
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        cnt = 0;
      end
      if (pmem_read || pmem_write) begin
        if (cnt == 0) begin
          st_addr = pmem_address;
          st_rw   = {pmem_read, pmem_write};
        end else begin
          chk("pmem_addr_stable", 32'(pmem_address),
              32'(st_addr));
          chk("pmem_rw_stable", 32'({pmem_read, pmem_write}),
              32'(st_rw));
        end
        cnt++;
        if (cnt >= delay) pmem_resp = 1'b1;
      end else begin
        cnt = 0;
      end
    end
  end

  // Scoreboard
  localparam int K_WB = 0, K_RD = 1, K_RESP = 2;
  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic        way;
    logic        wr;
  } exp_t;
  exp_t q[$];

  task automatic push(int kind, logic [15:0] addr,
                      logic way, logic wr);
    exp_t e;
    e.kind = kind; e.addr = addr; e.way = way; e.wr = wr;
    q.push_back(e);
  endtask

  logic prev_pr = 1'b0, prev_pw = 1'b0;
  logic fill_way = 1'b0;
  logic monitor_on = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (reset || !monitor_on) begin
      prev_pr = 1'b0;
      prev_pw = 1'b0;
    end else begin
      if (pmem_read && pmem_write) begin
        n_checks++; n_fail++;
        $display("FAIL pmem_both: read and write both high");
      end
      if (pmem_write && !prev_pw) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_wb: addr %h", pmem_address);
        end else begin
          e = q.pop_front();
          chk("wb_kind", 32'(e.kind), K_WB);
          chk("wb_addr", 32'(pmem_address), 32'(e.addr));
          chk("wb_way", 32'(way_sel), 32'(e.way));
        end
      end
      if (pmem_read && !prev_pr) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_rd: addr %h", pmem_address);
        end else begin
          e = q.pop_front();
          fill_way = e.way;
          chk("rd_kind", 32'(e.kind), K_RD);
          chk("rd_addr", 32'(pmem_address), 32'(e.addr));
        end
      end
      if ((pmem_read || pmem_write) && !pmem_resp)
        chk("no_load_wait",
            32'({load_TD0, load_TD1, load_v0, load_v1,
                 load_d0, load_d1}), 0);
      if (pmem_write && pmem_resp)
        chk("no_load_wb_resp",
            32'({load_TD0, load_TD1, load_v0, load_v1,
                 load_d0, load_d1}), 0);
      if (pmem_read && pmem_resp)
        chk("fill_ctrl",
            32'({load_TD0, load_v0, load_d0,
                 load_TD1, load_v1, load_d1,
                 v_in, d_in, data_sel}),
            32'({~fill_way, ~fill_way, ~fill_way,
                 fill_way, fill_way, fill_way,
                 3'b101}));
      if (mem_resp) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_resp: addr %h", mem_address);
        end else begin
          e = q.pop_front();
          chk("resp_kind", 32'(e.kind), K_RESP);
          chk("resp_way", 32'(way_sel), 32'(e.way));
          chk("resp_pmem_idle", 32'({pmem_read, pmem_write}), 0);
          if (e.wr)
            chk("wr_hit_ctrl",
                32'({load_TD0, load_d0, load_v0,
                     load_TD1, load_d1, load_v1,
                     d_in, v_in, data_sel}),
                32'({~e.way, ~e.way, ~e.way,
                     e.way, e.way, e.way, 3'b110}));
          else
            chk("rd_hit_noload",
                32'({load_TD0, load_TD1, load_d0, load_d1,
                     load_v0, load_v1}), 0);
        end
      end
      prev_pr = pmem_read;
      prev_pw = pmem_write;
    end
  end

  // Issue one request and require mem_resp on the given
  // cycle count (1 = first cycle of the request).
  task automatic do_req(string name, logic [15:0] addr,
                        logic rd, logic wr, int exp_cyc);
    int n;
    bit seen;
    mem_address = addr;
    mem_read    = rd;
    mem_write   = wr;
    n = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (mem_resp) seen = 1;
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: got no mem_resp expected resp",
               name);
    end else begin
      chk({name, "_latency"}, 32'(n), 32'(exp_cyc));
    end
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic check_sweep(string name);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk({name, "_index"}, 32'(index), 32'(i));
      chk({name, "_loads"},
          32'({load_v0, load_v1, load_d0, load_d1,
               v_in, d_in, mem_resp,
               pmem_read, pmem_write}),
          32'(9'b1111_00000));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bit seen;
    reset       = 1'b1;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = 16'h0000;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    monitor_on = 1'b1;
    check_sweep("init");

    // First idle cycle: nothing loaded, no response.
    @(negedge clk);
    chk("idle_quiet",
        32'({load_v0, load_v1, load_TD0, load_TD1,
             mem_resp, pmem_read, pmem_write}), 0);
    @(posedge clk); #1;

    // Clean miss into way 0, then retried hit.
    delay = 1;
    push(K_RD, 16'h1230, 1'b0, 1'b0);
    push(K_RESP, 16'h0, 1'b0, 1'b0);
    do_req("rd_1234", 16'h1234, 1'b1, 1'b0, 3);

    // Write hit, zero wait.
    push(K_RESP, 16'h0, 1'b0, 1'b1);
    do_req("wr_1236", 16'h1236, 1'b0, 1'b1, 1);

    // Clean miss into way 1 with slow pmem.
    delay = 5;
    push(K_RD, 16'h12B0, 1'b1, 1'b0);
    push(K_RESP, 16'h0, 1'b1, 1'b0);
    do_req("rd_12b0", 16'h12B0, 1'b1, 1'b0, 7);

    // Dirty victim way 0 written back, then refilled.
    delay = 1;
    push(K_WB, 16'h1230, 1'b0, 1'b0);
    push(K_RD, 16'h1330, 1'b0, 1'b0);
    push(K_RESP, 16'h0, 1'b0, 1'b0);
    do_req("rd_1330", 16'h1330, 1'b1, 1'b0, 4);

    // Way 1 still resident.
    push(K_RESP, 16'h0, 1'b1, 1'b0);
    do_req("rd_12b0_hit", 16'h12B0, 1'b1, 1'b0, 1);

    // Write miss with both strobes high: write wins.
    push(K_RD, 16'h0040, 1'b0, 1'b0);
    push(K_RESP, 16'h0, 1'b0, 1'b1);
    do_req("wr_0040", 16'h0040, 1'b1, 1'b1, 3);

    // Reset in the middle of an allocate.
    delay = 20;
    push(K_RD, 16'h5670, 1'b0, 1'b0);
    mem_address = 16'h5678;
    mem_read    = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (pmem_read) seen = 1;
    end
    chk("alloc_started", 32'(seen), 1);
    @(posedge clk); #1;
    reset    = 1'b1;
    mem_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check_sweep("resweep");

    // Everything invalidated: 0x1234 misses again.
    delay = 1;
    push(K_RD, 16'h1230, 1'b0, 1'b0);
    push(K_RESP, 16'h0, 1'b0, 1'b0);
    do_req("rd_1234_post", 16'h1234, 1'b1, 1'b0, 3);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
